// File: rtl/bus_dma_master_if.sv
// Bus-master port of the DMA engine as seen by the two-master arbiter.
// The master drives request/strobe/address/data; grant and read data come back.
interface bus_dma_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              M_req;
  logic              M_grant;
  logic              M_wr;
  logic [ADDR_W-1:0] M_addr;
  logic [DATA_W-1:0] M_dout;
  logic [DATA_W-1:0] M_din;

  modport master (
    output M_req, M_wr, M_addr, M_dout,
    input  M_grant, M_din
  );

  modport slave (
    input  M_req, M_wr, M_addr, M_dout,
    output M_grant, M_din
  );
endinterface

// File: rtl/bus_dma_master.sv
// Single-channel word copy engine: reads src, writes dst, one word per grant-qualified
// read/write pair, pulsing done when length words have moved.
module bus_dma_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  bus_dma_master_if.master  m
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Pointers only advance on a granted write, so a lost grant freezes the engine in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (length != '0)) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            cnt_q <= length;
          end
        end
        READ: begin
          if (m.M_grant) data_q <= m.M_din;
        end
        WRITE: begin
          if (m.M_grant) begin
            src_q <= src_q + 1'b1;
            dst_q <= dst_q + 1'b1;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    m.M_req  = 1'b0;
    m.M_wr   = 1'b0;
    m.M_addr = '0;
    m.M_dout = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (length == '0) ? DONE : READ;
      end
      READ: begin
        m.M_req  = 1'b1;
        m.M_addr = src_q;
        if (m.M_grant) state_d = WRITE;
      end
      WRITE: begin
        // Strobe follows the grant combinationally so an ungranted cycle never writes.
        m.M_req  = 1'b1;
        m.M_addr = dst_q;
        m.M_dout = data_q;
        m.M_wr   = m.M_grant;
        if (m.M_grant) state_d = (cnt_q == LEN_W'(1)) ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: ROM-style slave with a write logger, scoreboard of expected
// writes (address, data, cycle) and done cycles.
module tb_bus_dma_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] src_addr = '0;
  logic [7:0] dst_addr = '0;
  logic [3:0] length = '0;
  logic       busy, done;
  logic       grant_en = 1'b1;
  int         cyc = 0;

  logic [31:0] mem [256];

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t wq[$];
  int  dq[$];

  int n_checks = 0;
  int n_errors = 0;

  bus_dma_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  assign bus.M_grant = bus.M_req & grant_en;
  assign bus.M_din   = mem[bus.M_addr];

  bus_dma_master #(.ADDR_W(8), .DATA_W(32), .LEN_W(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .m        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected writes/done for a transfer; stall_n cycles of lost grant in the write of stall_word.
  task automatic push_expect(input logic [7:0] s, input logic [7:0] d, input int len,
                             input int kp1, input int stall_word, input int stall_n);
    wr_t e;
    int  extra;
    for (int i = 0; i < len; i++) begin
      extra  = (i >= stall_word) ? stall_n : 0;
      e.addr = d + 8'(i);
      e.data = mem[s + 8'(i)];
      e.cyc  = kp1 + 1 + 2 * i + extra;
      wq.push_back(e);
    end
    dq.push_back(kp1 + 2 * len + ((len > stall_word) ? stall_n : 0));
  endtask

  task automatic start_xfer(input logic [7:0] s, input logic [7:0] d, input logic [3:0] len,
                            output int kp1);
    @(negedge clk);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    length   = len;
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_addr = 8'($urandom);
    dst_addr = 8'($urandom);
    length   = 4'($urandom);
    kp1      = cyc;
    check("start_busy", busy, 1'b1);
    check("start_req", bus.M_req, (len != 4'd0));
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 1000 && cyc < target; i++) begin
      @(posedge clk);
      #1;
    end
    if (cyc != target) check("wait_cycle", cyc, target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("idle_reached", busy, 1'b0);
    check("sb_writes_left", wq.size(), 0);
    check("sb_done_left", dq.size(), 0);
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_req"}, bus.M_req, 1'b0);
    check({tag, "_wr"}, bus.M_wr, 1'b0);
    check({tag, "_addr"}, bus.M_addr, 8'h00);
    check({tag, "_dout"}, bus.M_dout, 32'h0);
  endtask

  // Bus monitor: every write and done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.M_wr) begin
        check("wr_granted", bus.M_grant, 1'b1);
        if (wq.size() == 0) check("wr_unexpected", 1'b1, 1'b0);
        else begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", bus.M_addr, e.addr);
          check("wr_data", bus.M_dout, e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (dq.size() == 0) check("done_unexpected", 1'b1, 1'b0);
        else check("done_cycle", cyc, dq.pop_front());
      end
      if (busy && !done) check("req_held", bus.M_req, 1'b1);
      else begin
        check("quiet_req", bus.M_req, 1'b0);
        check("quiet_addr", bus.M_addr, 8'h00);
        check("quiet_dout", bus.M_dout, 32'h0);
      end
    end
  end

  initial begin
    int kp1, kp1b;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + i * 32'h0001_0101;

    // Reset held with arbitrary inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      start    = 1'($urandom);
      src_addr = 8'($urandom);
      length   = 4'($urandom);
      @(negedge clk);
      check_all_low("rst0");
    end
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst0_idle", busy, 1'b0);

    // Basic 3-word copy, with an ignored start mid-transfer
    start_xfer(8'h10, 8'h40, 4'd3, kp1);
    push_expect(8'h10, 8'h40, 3, kp1, 99, 0);
    wait_cyc(kp1 + 2);
    start    = 1'b1;
    src_addr = 8'h80;
    dst_addr = 8'h90;
    length   = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();

    // Same copy with grant withdrawn for 3 cycles during the write of word 1
    start_xfer(8'h10, 8'h40, 4'd3, kp1);
    push_expect(8'h10, 8'h40, 3, kp1, 1, 3);
    wait_cyc(kp1 + 3);
    grant_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_wr", bus.M_wr, 1'b0);
      check("stall_req", bus.M_req, 1'b1);
      check("stall_addr", bus.M_addr, 8'h41);
    end
    @(posedge clk);
    #1;
    grant_en = 1'b1;
    wait_idle();

    // Zero-length no-op
    start_xfer(8'h22, 8'h33, 4'd0, kp1);
    push_expect(8'h22, 8'h33, 0, kp1, 99, 0);
    check("len0_done", done, 1'b1);
    wait_idle();

    // Address wrap-around
    start_xfer(8'hFE, 8'hFF, 4'd3, kp1);
    push_expect(8'hFE, 8'hFF, 3, kp1, 99, 0);
    wait_idle();

    // Start at the edge ending DONE is ignored; accepted one cycle later
    start_xfer(8'h05, 8'h70, 4'd1, kp1);
    push_expect(8'h05, 8'h70, 1, kp1, 99, 0);
    wait_cyc(kp1 + 2);
    check("restart_in_done", done, 1'b1);
    start    = 1'b1;
    src_addr = 8'h20;
    dst_addr = 8'h60;
    length   = 4'd2;
    @(posedge clk);
    #1;
    check("restart_ignored", busy, 1'b0);
    kp1b = cyc + 1;
    push_expect(8'h20, 8'h60, 2, kp1b, 99, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("restart_accepted", busy, 1'b1);
    wait_idle();

    // Reset dropped during WRITE: abandoned, no write of that word, no done
    start_xfer(8'h30, 8'h50, 4'd4, kp1);
    wait_cyc(kp1 + 1);
    check("pre_rst_wr", bus.M_wr, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_low("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      start    = 1'($urandom);
      src_addr = 8'($urandom);
      length   = 4'($urandom);
      @(negedge clk);
      check_all_low("rst_hold");
    end
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_idle_busy", busy, 1'b0);
    check("rst_idle_req", bus.M_req, 1'b0);
    check("rst_sb_empty", wq.size() + dq.size(), 0);

    // Engine usable after reset
    start_xfer(8'h10, 8'h60, 4'd2, kp1);
    push_expect(8'h10, 8'h60, 2, kp1, 99, 0);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_dma_master.md
# bus_dma_master

Single-channel copy engine that sits upstream of the two-master bus arbiter as a bus master. On a start pulse it copies `length` consecutive words from a source to a destination region. It does this by asserting its request line, moving data only in cycles where the arbiter grants it the bus, and reporting completion with a one-cycle pulse. One instance drives either master port (M0 or M1) of the arbiter.

## Interface
- `ADDR_W`, 8, bus address width
- `DATA_W`, 32, bus data width
- `LEN_W`, 4, width of the word-count field
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  transfer start; sampled only in IDLE
- `src_addr`  in  ADDR_W  first source word address; latched on accepted start
- `dst_addr`  in  ADDR_W  first destination word address; latched on accepted start
- `length`  in  LEN_W  number of words to copy; latched on accepted start; 0 means no-op
- `busy`  out  1  high from the cycle after an accepted start until the DONE cycle, inclusive
- `done`  out  1  one-cycle completion pulse
- `M_req`  out  1  bus request to the arbiter
- `M_grant`  in  1  bus grant from the arbiter; may change combinationally with `M_req`
- `M_wr`  out  1  bus write strobe
- `M_addr`  out  ADDR_W  bus address
- `M_dout`  out  DATA_W  bus write data
- `M_din`  in  DATA_W  bus read data; the slave returns it combinationally in the same cycle as `M_addr`

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Registers:
  - `src`, `dst` (ADDR_W)
  - `cnt` (LEN_W)
  - `data` (DATA_W)
- IDLE:
  - `start`=1 and `length`!=0: latch `src`/`dst`/`cnt`, go to READ.
  - `start`=1 and `length`=0: go to DONE.
  - Otherwise stay in IDLE.
- READ:
  - `M_req`=1, `M_addr`=`src`, `M_wr`=0.
  - If `M_grant`=1 at the edge: `data`<=`M_din`, go to WRITE.
  - Otherwise stay in READ; `data` is unchanged.
- WRITE:
  - `M_req`=1, `M_addr`=`dst`, `M_dout`=`data`, `M_wr`=`M_grant`. The strobe is gated combinationally by the grant.
  - If `M_grant`=1 at the edge: `src`<=`src`+1, `dst`<=`dst`+1, `cnt`<=`cnt`-1. Next state is DONE if `cnt`=1, else READ.
  - Otherwise stay in WRITE and hold all registers.
- DONE: `M_req`=0, `done`=1, next state IDLE unconditionally.
- Outputs in IDLE and DONE:
  - `M_req`=0, `M_wr`=0.
  - `M_addr`=0, `M_dout`=0. Bus outputs are zeroed so that the arbiter's bus mux sees a quiet master.
- `M_req` is high for the whole of READ and WRITE. It never drops between words of one transfer.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent and allowed.
- Grant loss at any point pauses the engine. It resumes at the same address and phase when the grant returns. No word is skipped or repeated.
- `start` while not in IDLE is ignored, including in DONE. Inputs presented with an ignored start are not latched.
- Async reset at any time, including mid-transfer:
  - Every output goes low immediately.
  - The FSM goes to IDLE and every register is cleared.
  - The transfer is abandoned, with no `done` pulse.

## Timing
- Reset values: `busy`=0, `done`=0, `M_req`=0, `M_wr`=0, `M_addr`=0, `M_dout`=0.
- Start sampled at edge k:
  - `M_req`=1 and `busy`=1 in cycle k+1.
- With `M_grant` continuously 1:
  - Each word takes 2 cycles: read in cycle k+1+2i, write in cycle k+2+2i.
  - `done` is high in cycle k+1+2N.
- Each cycle in READ or WRITE with `M_grant`=0 adds exactly one cycle of latency.
- `length`=0: `done` is high in cycle k+1, `busy`=1 in that cycle only, and `M_req` is never asserted.
- Earliest accepted restart: `start` sampled at the edge ending the DONE cycle is ignored. The next start is accepted one cycle later, from IDLE.

## Test plan
- Reset asserted mid-stream with arbitrary inputs -> all six outputs 0 while `reset_n`=0; FSM in IDLE after release.
- `src`=0x10, `dst`=0x40, `length`=3, grant tied 1, memory model with mem[0x10..0x12]=A,B,C -> writes A,B,C to 0x40,0x41,0x42 in cycles k+2, k+4, k+6; `done` at k+7; `M_req` high k+1..k+6.
- Same transfer, grant forced 0 for 3 cycles while in WRITE of word 1 -> `M_wr`=0 in those cycles; B is written to 0x41 once, when grant returns; `done` at k+10.
- `length`=0 -> `done` at k+1; `M_req` never high; no bus write.
- ADDR_W=8, `src`=0xFE, `dst`=0xFF, `length`=3 -> reads 0xFE,0xFF,0x00 and writes 0xFF,0x00,0x01.
- `start` pulsed again during a transfer with different inputs -> ignored, original copy completes. Separately, `reset_n` dropped in WRITE -> `M_req`/`M_wr` go low asynchronously, with no `done` pulse.
